mii_tx_frame_sink: RTL and testbench

//  PHY-side receiver for the MAC's MII transmit pins (mii_txd/mii_tx_en/mii_tx_er).
//  - Strips preamble/SFD, packs nibbles into bytes (low nibble first), emits frames on an 8-bit AXIS master.
//  - Serves as loopback/bring-up sink and bench monitor for the Ethernet MAC path. Runs on the 25 MHz MII clock.

---
 rtl/mii_tx_frame_sink.sv | 235 +++++++++++++++++++++++
 tb/tb_mii_tx_frame_sink.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_tx_frame_sink.sv
// MII transmit-pin sink: strips preamble/SFD, packs nibbles into AXIS bytes.
// Define MII_SINK_FCS_CHECK_EN to flag frames whose CRC-32 residue is wrong.
module mii_tx_frame_sink #(
  parameter int FIFO_DEPTH   = 16,
  parameter int MIN_PREAMBLE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  mii_txd,
  input  logic        mii_tx_en,
  input  logic        mii_tx_er,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] MIN_PRE = 4'(MIN_PREAMBLE);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_FIN, S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_q, pre_d;
  logic        odd_q, odd_d;
  logic [3:0]  lo_q, lo_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_v_q, hold_v_d;
  logic        err_q, err_d;
  logic        late_q, late_d;
  logic [7:0]  new_byte;
  logic        byte_done;
  logic        frm_inc, err_inc;
  logic        crc_bad;

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt_q;
  logic        push, pop, can_push;
  logic [9:0]  push_data;
  logic [9:0]  head;

  assign new_byte = {mii_txd, lo_q};
  assign pop      = m_axis_tvalid & m_axis_tready;
  assign can_push = (cnt_q != FULL_CNT) | pop;

`ifdef MII_SINK_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign crc_bad = (crc_q != 32'hDEBB20E3);

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_PRE && state_d == S_DATA)
      crc_d = 32'hFFFFFFFF;
    else if (byte_done)
      crc_d = crc_step(crc_q, new_byte);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) crc_q <= 32'hFFFFFFFF;
    else       crc_q <= crc_d;
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    odd_d     = odd_q;
    lo_d      = lo_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    err_d     = err_q;
    late_d    = late_q;
    push      = 1'b0;
    push_data = '0;
    byte_done = 1'b0;
    frm_inc   = 1'b0;
    err_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mii_tx_en) begin
          if (mii_txd == 4'h5) begin
            state_d = S_PRE;
            pre_d   = 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!mii_tx_en) begin
          state_d = S_IDLE;
          err_inc = 1'b1;
        end else if (mii_txd == 4'h5) begin
          if (pre_q != 4'hF) pre_d = pre_q + 4'd1;
        end else if (mii_txd == 4'hD && pre_q >= MIN_PRE) begin
          state_d  = S_DATA;
          odd_d    = 1'b0;
          hold_v_d = 1'b0;
          err_d    = 1'b0;
        end else begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!mii_tx_en) begin
          state_d = S_FIN;
          late_d  = 1'b0;
          if (odd_q) err_d = 1'b1;
        end else begin
          if (mii_tx_er) err_d = 1'b1;
          odd_d = ~odd_q;
          if (!odd_q) begin
            lo_d = mii_txd;
          end else begin
            byte_done = 1'b1;
            if (!hold_v_q) begin
              hold_d   = new_byte;
              hold_v_d = 1'b1;
            end else if (can_push) begin
              push      = 1'b1;
              push_data = {2'b00, hold_q};
              hold_d    = new_byte;
            end else begin
              // overflow: drop the new byte, keep hold for tlast
              err_d = 1'b1;
            end
          end
        end
      end
      S_FIN: begin
        if (mii_tx_en) late_d = 1'b1;
        if (!hold_v_q) begin
          err_inc = 1'b1;
          state_d = (mii_tx_en | late_q) ? S_DROP : S_IDLE;
        end else if (can_push) begin
          push      = 1'b1;
          push_data = {1'b1, err_q | crc_bad, hold_q};
          frm_inc   = 1'b1;
          err_inc   = err_q | crc_bad;
          hold_v_d  = 1'b0;
          // a frame that began during the stall is discarded
          state_d   = (mii_tx_en | late_q) ? S_DROP : S_IDLE;
        end
      end
      S_DROP: begin
        if (!mii_tx_en) begin
          state_d = S_IDLE;
          err_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      odd_q    <= 1'b0;
      lo_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      err_q    <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      odd_q    <= odd_d;
      lo_q     <= lo_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      err_q    <= err_d;
      late_q   <= late_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (frm_inc) frame_count <= frame_count + 16'd1;
      if (err_inc && error_count != 16'hFFFF)
        error_count <= error_count + 16'd1;
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tdata  = head[7:0];
  assign m_axis_tuser  = head[8];
  assign m_axis_tlast  = head[9];
  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tkeep  = 1'b1;

endmodule

// File: tb/tb_mii_tx_frame_sink.sv
// Randomized bench for mii_tx_frame_sink with a frame-level reference model.
// Build with MII_SINK_FCS_CHECK_EN to match a DUT built the same way.
`timescale 1ns/1ps
module tb_mii_tx_frame_sink;

  localparam int DEPTH   = 16;
  localparam int MIN_PRE = 2;
`ifdef MII_SINK_FCS_CHECK_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mii_txd = '0;
  logic        mii_tx_en = 1'b0;
  logic        mii_tx_er = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] frame_count;
  logic [15:0] error_count;

  always #20 clock = ~clock;

  mii_tx_frame_sink #(
    .FIFO_DEPTH(DEPTH),
    .MIN_PREAMBLE(MIN_PRE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mii_txd(mii_txd),
    .mii_tx_en(mii_tx_en),
    .mii_tx_er(mii_tx_er),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .frame_count(frame_count),
    .error_count(error_count)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  logic [3:0] nibs[$];
  logic [7:0] mb[$];
  int n_chk = 0;
  int n_err = 0;
  int beats = 0;
  int edges = 0;
  int last_edge = 0;
  int tlast_edge = 0;
  int exp_frames = 0;
  int exp_errors = 0;
  logic rand_mode = 1'b0;
  logic rdy_fixed = 1'b1;
  logic rdy_rand  = 1'b1;

  assign m_axis_tready = rand_mode ? rdy_rand : rdy_fixed;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) edges++;

  always @(posedge clock) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tdata", 32'(m_axis_tdata), 32'(mon_e.d));
        chk("tlast", 32'(m_axis_tlast), 32'(mon_e.l));
        if (mon_e.l) begin
          chk("tuser", 32'(m_axis_tuser), 32'(mon_e.u));
          tlast_edge = edges;
        end
      end
    end
  end

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, mb[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input int n, input bit fcs);
    logic [31:0] f;
    mb.delete();
    nibs.delete();
    for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
    if (fcs) begin
      f = crc_of(n);
      for (int i = 0; i < 4; i++) mb.push_back(f[8*i +: 8]);
    end
    foreach (mb[i]) begin
      nibs.push_back(mb[i][3:0]);
      nibs.push_back(mb[i][7:4]);
    end
  endtask

  // Frame-level model: preamble rule, byte pairing, error sources.
  task automatic model(input int npre, input logic [3:0] sfd,
                       input int er_at);
    int nb;
    bit odd, er, fcs_ok, bad;
    if (npre < MIN_PRE || sfd != 4'hD) begin
      exp_errors++;
      return;
    end
    nb  = nibs.size() / 2;
    odd = (nibs.size() % 2) == 1;
    if (nb == 0) begin
      exp_errors++;
      return;
    end
    mb.delete();
    for (int i = 0; i < nb; i++) mb.push_back({nibs[2*i+1], nibs[2*i]});
    er = (er_at >= 0) && (er_at < nibs.size());
    fcs_ok = (nb >= 4) &&
             (crc_of(nb-4) == {mb[nb-1], mb[nb-2], mb[nb-3], mb[nb-4]});
    bad = er | odd | (FCS_ON && !fcs_ok);
    for (int i = 0; i < nb; i++)
      exp_q.push_back('{d: mb[i], l: (i == nb-1), u: (i == nb-1) && bad});
    exp_frames++;
    if (bad) exp_errors++;
  endtask

  task automatic drive(input logic en, input logic [3:0] d, input logic er);
    @(posedge clock);
    #1;
    mii_tx_en = en;
    mii_txd   = d;
    mii_tx_er = er;
  endtask

  task automatic drive_frame(input int npre, input logic [3:0] sfd,
                             input int er_at);
    repeat (npre) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, sfd, 1'b0);
    foreach (nibs[i]) drive(1'b1, nibs[i], i == er_at);
    last_edge = edges;
    repeat (12) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic send(input int npre, input logic [3:0] sfd, input int er_at);
    model(npre, sfd, er_at);
    drive_frame(npre, sfd, er_at);
  endtask

  task automatic drain_check(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk({tag, "_drain"}, 32'(t < 3000), 32'd1);
    repeat (4) @(negedge clock);
    chk({tag, "_frames"}, 32'(frame_count), 32'(exp_frames));
    chk({tag, "_errors"}, 32'(error_count), 32'(exp_errors));
  endtask

  // 40 bytes into a stalled sink: first 16 fill the FIFO, byte 17 stays
  // in hold and becomes the flagged tlast beat.
  task automatic expect_overflow();
    build(40, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back('{d: mb[i], l: 1'b0, u: 1'b0});
    exp_q.push_back('{d: mb[DEPTH], l: 1'b1, u: 1'b1});
    exp_frames++;
    exp_errors++;
  endtask

  int b0;
  int npre, nby, er_at;
  logic [3:0] sfd;

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst_frames", 32'(frame_count),   32'd0);
    chk("rst_errors", 32'(error_count),   32'd0);
    chk("tkeep",      32'(m_axis_tkeep),  32'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // good 64-byte frame with FCS, 7 preamble nibbles
    build(60, 1'b1);
    b0 = beats;
    send(7, 4'hD, -1);
    drain_check("t1");
    chk("t1_beats", 32'(beats - b0), 32'd64);
    chk("t1_latency", 32'(tlast_edge - (last_edge + 1)), 32'd2);

    // one flipped payload nibble
    nibs[30] = nibs[30] ^ 4'h2;
    b0 = beats;
    send(7, 4'hD, -1);
    drain_check("t2");
    chk("t2_beats", 32'(beats - b0), 32'd64);

    // tx_er mid-data
    build(30, 1'b1);
    send(7, 4'hD, 21);
    drain_check("t3");

    // SFD after a single 0x5, then a clean frame
    build(20, 1'b1);
    b0 = beats;
    send(1, 4'hD, -1);
    drain_check("t4_early");
    chk("t4_beats", 32'(beats - b0), 32'd0);
    send(7, 4'hD, -1);
    drain_check("t4_good");

    // stalled output: overflow, tlast held until space frees
    rdy_fixed = 1'b0;
    expect_overflow();
    b0 = beats;
    drive_frame(7, 4'hD, -1);
    repeat (20) @(negedge clock);
    chk("t5_stall_beats",  32'(beats - b0),   32'd0);
    chk("t5_stall_valid",  32'(m_axis_tvalid), 32'd1);
    chk("t5_stall_frames", 32'(frame_count),  32'(exp_frames - 1));
    rdy_fixed = 1'b1;
    drain_check("t5");
    chk("t5_beats", 32'(beats - b0), 32'd17);

    // a frame arriving while the tlast write is stalled is dropped
    rdy_fixed = 1'b0;
    expect_overflow();
    b0 = beats;
    drive_frame(7, 4'hD, -1);
    build(10, 1'b1);
    exp_errors++;
    drive_frame(7, 4'hD, -1);
    rdy_fixed = 1'b1;
    drain_check("t5b");
    chk("t5b_beats", 32'(beats - b0), 32'd17);

    // randomized frames under random backpressure
    rand_mode = 1'b1;
    for (int f = 0; f < 30; f++) begin
      npre = $urandom_range(0, 9);
      sfd  = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'hD;
      nby  = $urandom_range(0, 11);
      build(nby, (nby > 0) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 4) == 0) nibs.push_back(4'($urandom));
      er_at = -1;
      if (nibs.size() > 0 && $urandom_range(0, 7) == 0)
        er_at = $urandom_range(0, nibs.size() - 1);
      send(npre, sfd, er_at);
      drain_check("rnd");
    end
    rand_mode = 1'b0;

    // reset in the middle of frame data
    rdy_fixed = 1'b0;
    build(20, 1'b0);
    repeat (7) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, nibs[i], 1'b0);
    #1 reset = 1'b1;
    mii_tx_en = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_errors = 0;
    @(negedge clock);
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_frames", 32'(frame_count),   32'd0);
    chk("t6_errors", 32'(error_count),   32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    rdy_fixed = 1'b1;
    build(40, 1'b1);
    b0 = beats;
    send(7, 4'hD, -1);
    drain_check("t6");
    chk("t6_beats", 32'(beats - b0), 32'd44);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
